// File: rtl/ps8_requester.sv
// Requester side of the 8-way fixed-priority selector: per-channel pending counters,
// req/en generation, grant retirement and reporting, selector sanity checks, starvation flags.
module ps8_requester #(
  parameter int CNT_W      = 4,
  parameter int AGE_W      = 8,
  parameter int STARVE_LIM = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [2:0]       issue_ch,
  output logic             issue_ready,
  input  logic             stall,
  output logic [7:0]       req,
  output logic             en,
  input  logic [7:0]       gnt,
  input  logic             req_up,
  output logic             grant_valid,
  output logic [2:0]       grant_ch,
  output logic [CNT_W+2:0] outstanding,
  output logic [3:0]       err,
  output logic [7:0]       starve
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(STARVE_LIM);

  logic [CNT_W-1:0]   pend     [8];
  logic [CNT_W-1:0]   pend_nxt [8];
  logic [AGE_W-1:0]   age      [8];
  logic [AGE_W-1:0]   age_nxt  [8];
  logic [7:0]         inc;
  logic [7:0]         dec;
  logic [7:0]         starve_nxt;
  logic               multi_hot;
  logic               legal;
  logic               accept;
  logic [2:0]         gnt_idx;
  logic [3:0]         err_now;
  logic [CNT_W+2:0]   outstanding_nxt;

  always_comb begin
    for (int i = 0; i < 8; i++) req[i] = (pend[i] != '0);
  end

  assign en          = ~stall;
  assign issue_ready = (pend[issue_ch] != CNT_MAX);
  assign accept      = issue_valid & issue_ready;
  assign multi_hot   = ((gnt & (gnt - 8'd1)) != 8'd0);
  // One-hot, aimed at a requesting channel, and only while enabled.
  assign legal       = (gnt != 8'd0) && !multi_hot && ((gnt & ~req) == 8'd0) && en;

  always_comb begin
    gnt_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (gnt[i]) gnt_idx = 3'(i);
    end
  end

  always_comb begin
    err_now    = 4'd0;
    err_now[0] = multi_hot;
    err_now[1] = ((gnt & ~req) != 8'd0) || ((gnt != 8'd0) && !en);
    err_now[2] = en && (req != 8'd0) && (gnt == 8'd0);
    err_now[3] = (req_up != (req != 8'd0));
  end

  always_comb begin
    inc        = 8'd0;
    dec        = 8'd0;
    starve_nxt = starve;
    for (int i = 0; i < 8; i++) begin
      inc[i]      = accept && (issue_ch == 3'(i));
      dec[i]      = legal && gnt[i];
      pend_nxt[i] = pend[i] + CNT_W'(inc[i]) - CNT_W'(dec[i]);
      if (!req[i] || dec[i])
        age_nxt[i] = '0;
      else if (age[i] != AGE_MAX)
        age_nxt[i] = age[i] + AGE_W'(1);
      else
        age_nxt[i] = age[i];
      starve_nxt[i] = starve[i] | (age_nxt[i] >= AGE_LIM);
    end
    outstanding_nxt = outstanding + (CNT_W+3)'(accept) - (CNT_W+3)'(legal);
  end

  // Reset wins over any grant presented in the same cycle; nothing is recorded for it.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        pend[i] <= '0;
        age[i]  <= '0;
      end
      outstanding <= '0;
      grant_valid <= 1'b0;
      grant_ch    <= 3'd0;
      err         <= 4'd0;
      starve      <= 8'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        pend[i] <= pend_nxt[i];
        age[i]  <= age_nxt[i];
      end
      outstanding <= outstanding_nxt;
      grant_valid <= legal;
      if (legal) grant_ch <= gnt_idx;
      err         <= err | err_now;
      starve      <= starve_nxt;
    end
  end

endmodule

// File: tb/tb_ps8_requester.sv
// Scoreboard bench for ps8_requester: a cycle-level reference model predicts state and
// grant reports; a separate monitor pops expected grant channels when grant_valid is seen.
module tb_ps8_requester;

  localparam int LIM  = 32;
  localparam int MAXP = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       issue_valid = 1'b0;
  logic [2:0] issue_ch = 3'd0;
  logic       issue_ready;
  logic       stall = 1'b0;
  logic [7:0] req;
  logic       en;
  logic [7:0] gnt = 8'd0;
  logic       req_up = 1'b0;
  logic       grant_valid;
  logic [2:0] grant_ch;
  logic [6:0] outstanding;
  logic [3:0] err;
  logic [7:0] starve;

  ps8_requester #(.CNT_W(4), .AGE_W(8), .STARVE_LIM(LIM)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_ch(issue_ch),
    .issue_ready(issue_ready), .stall(stall), .req(req), .en(en), .gnt(gnt),
    .req_up(req_up), .grant_valid(grant_valid), .grant_ch(grant_ch),
    .outstanding(outstanding), .err(err), .starve(starve)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // reference model state
  int       mpend [8];
  int       mout = 0;
  bit       mgv  = 1'b0;
  bit [3:0] merr = 4'd0;
  bit [7:0] mst  = 8'd0;
  int       since [8];
  int       cyc = 0;
  int       q [$];

  // stimulus controls
  bit       d_iv = 0;
  bit [2:0] d_ch = 0;
  bit       d_stall = 0;
  bit       d_rst = 1;
  bit       force_gnt = 0;
  bit [7:0] forced_gnt = 0;
  bit       force_rup = 0;
  bit       forced_rup = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit [7:0] model_req();
    bit [7:0] r = 0;
    for (int i = 0; i < 8; i++) r[i] = (mpend[i] != 0);
    return r;
  endfunction

  // ideal fixed-priority selector: highest index wins
  function automatic bit [7:0] ideal_sel(input bit [7:0] r, input bit e);
    bit [7:0] g = 0;
    if (e) for (int i = 0; i < 8; i++) if (r[i]) g = 8'b1 << i;
    return g;
  endfunction

  task automatic step();
    bit [7:0] r;
    bit       rdy;
    bit       legal;
    bit       acc;
    int       idx;
    @(negedge clock);
    r = model_req();
    check("req", req, r);
    check("outstanding", outstanding, mout);
    check("grant_valid", grant_valid, mgv);
    check("err", err, merr);
    check("starve", starve, mst);
    reset       = d_rst;
    issue_valid = d_iv;
    issue_ch    = d_ch;
    stall       = d_stall;
    gnt         = force_gnt ? forced_gnt : ideal_sel(r, !d_stall);
    req_up      = force_rup ? forced_rup : (r != 0);
    #1;
    rdy = (mpend[d_ch] != MAXP);
    check("issue_ready", issue_ready, rdy);
    check("en", en, !d_stall);
    if (d_rst) begin
      for (int i = 0; i < 8; i++) begin mpend[i] = 0; since[i] = cyc + 1; end
      mout = 0; mgv = 0; merr = 0; mst = 0;
    end else begin
      legal = ($countones(gnt) == 1) && ((gnt & ~r) == 0) && !d_stall;
      acc   = d_iv && rdy;
      if ($countones(gnt) > 1) merr[0] = 1;
      if (((gnt & ~r) != 0) || (gnt != 0 && d_stall)) merr[1] = 1;
      if (!d_stall && r != 0 && gnt == 0) merr[2] = 1;
      if (req_up != (r != 0)) merr[3] = 1;
      mgv = legal;
      if (legal) begin
        idx = $clog2(gnt);
        mpend[idx]--; mout--;
        q.push_back(idx);
      end
      if (acc) begin mpend[d_ch]++; mout++; end
      for (int i = 0; i < 8; i++) begin
        if (!r[i] || (legal && gnt[i])) since[i] = cyc + 1;
        else if (cyc + 1 - since[i] >= LIM) mst[i] = 1;
      end
    end
    cyc++;
  endtask

  task automatic drive(input bit iv, input bit [2:0] ch, input bit st, input bit rst);
    d_iv = iv; d_ch = ch; d_stall = st; d_rst = rst;
    step();
  endtask

  // monitor: every reported grant must match the oldest predicted one
  always @(posedge clock) begin
    #1;
    if (grant_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL grant_report: got ch %0d want none", grant_ch);
      end else begin
        check("grant_ch", grant_ch, q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) begin mpend[i] = 0; since[i] = 0; end
    repeat (2) drive(0, 0, 0, 1);

    // three on ch5, one on ch2, then release the selector
    repeat (3) drive(1, 5, 1, 0);
    drive(1, 2, 1, 0);
    repeat (6) drive(0, 0, 0, 0);

    // fill ch0 past full, then issue and grant together
    repeat (17) drive(1, 0, 1, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    repeat (16) drive(0, 0, 0, 0);

    // multi-hot grant on a legitimately requesting pair
    drive(1, 1, 1, 0);
    drive(1, 2, 1, 0);
    force_gnt = 1; forced_gnt = 8'b0000_0110;
    drive(0, 0, 0, 0);
    force_gnt = 0;
    repeat (4) drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);

    // ch7 kept busy while ch0 starves
    drive(1, 7, 1, 0);
    drive(1, 0, 1, 0);
    repeat (40) drive(1, 7, 0, 0);
    repeat (4) drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);

    // stall and selector misbehaviour
    drive(1, 3, 1, 0);
    force_gnt = 1; forced_gnt = 8'h01;
    drive(0, 0, 1, 0);
    forced_gnt = 8'h00;
    drive(0, 0, 0, 0);
    force_gnt = 0; force_rup = 1; forced_rup = 0;
    drive(0, 0, 0, 0);
    force_rup = 0;
    drive(0, 0, 0, 1);

    // reset with ch3 pending and a grant in flight
    repeat (5) drive(1, 3, 1, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 149) == 0);
    end
    repeat (130) drive(0, 0, 0, 0);

    check("grants_left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
